// File: rtl/reg_file_param_if.sv
// Bundle of the register file's bus signals: software write/read ports, hardware
// write-back channels, dirty/overrun status and the peripheral mirror.
interface reg_file_param_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 3,
  parameter int HW_CH   = 2,
  parameter int PER_CNT = 8
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic                       write_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W/8-1:0]        wr_be;
  logic [DATA_W-1:0]          DataIn;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [HW_CH-1:0]           hw_wr_en;
  logic [HW_CH*ADDR_W-1:0]    hw_addr;
  logic [HW_CH*DATA_W-1:0]    hw_mask;
  logic [HW_CH*DATA_W-1:0]    hw_data;
  logic                       dirty_clr;
  logic [ADDR_W-1:0]          dirty_addr;
  logic                       ovf_clr;
  logic [NUM_REGS-1:0]        dirty;
  logic                       ovf;
  logic [PER_CNT*DATA_W-1:0]  per_regs;

  modport master (
    output write_en, wr_addr, wr_be, DataIn, rd_addr,
    output hw_wr_en, hw_addr, hw_mask, hw_data,
    output dirty_clr, dirty_addr, ovf_clr,
    input  rd_data, dirty, ovf, per_regs
  );

  modport slave (
    input  write_en, wr_addr, wr_be, DataIn, rd_addr,
    input  hw_wr_en, hw_addr, hw_mask, hw_data,
    input  dirty_clr, dirty_addr, ovf_clr,
    output rd_data, dirty, ovf, per_regs
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: r0 hard-wired to zero, byte-enabled software port,
// masked hardware write-back channels with dirty/overrun tracking, peripheral mirror.
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter int HW_CH    = 2,
  parameter int BYPASS   = 1,
  parameter int PER_BASE = 8,
  parameter int PER_CNT  = 8
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_param_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NB       = DATA_W/8;

  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q;
  logic [NUM_REGS-1:0] dirty_set;
  logic [NUM_REGS-1:0] dirty_clr_v;
  logic                ovf_q;
  logic                ovf_set;
  logic                hit_seen;
  logic [ADDR_W-1:0]   rd_a;

  // Next value of every register: hardware channels merge in index order so the
  // higher channel wins per bit, then software byte lanes override on top.
  // NOTE: every variable written here gets a default first, otherwise latches are inferred.
  always_comb begin
    ovf_set  = 1'b0;
    hit_seen = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_nxt[r]    = regs[r];
      dirty_set[r]   = 1'b0;
      dirty_clr_v[r] = 1'b0;
      if (r != 0) begin
        hit_seen = 1'b0;
        for (int c = 0; c < HW_CH; c++) begin
          if (bus.hw_wr_en[c] && bus.hw_addr[c*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
            regs_nxt[r] = (regs_nxt[r] & ~bus.hw_mask[c*DATA_W +: DATA_W])
                        | (bus.hw_data[c*DATA_W +: DATA_W] & bus.hw_mask[c*DATA_W +: DATA_W]);
            if (hit_seen) ovf_set = 1'b1;
            hit_seen = 1'b1;
            if (bus.hw_mask[c*DATA_W +: DATA_W] != '0) begin
              dirty_set[r] = 1'b1;
              if (dirty_q[r]) ovf_set = 1'b1;
            end
          end
        end
        if (bus.write_en && bus.wr_addr == ADDR_W'(r)) begin
          dirty_clr_v[r] = 1'b1;
          for (int b = 0; b < NB; b++) begin
            if (bus.wr_be[b]) regs_nxt[r][b*8 +: 8] = bus.DataIn[b*8 +: 8];
          end
        end
        if (bus.dirty_clr && bus.dirty_addr == ADDR_W'(r)) dirty_clr_v[r] = 1'b1;
      end
    end
  end

  // Bypass returns the full next value, so hardware merges show through the
  // byte lanes software did not enable.
  always_comb begin
    rd_a         = '0;
    bus.rd_data  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (BYPASS != 0 && bus.write_en && bus.wr_addr == rd_a && rd_a != '0)
        bus.rd_data[p*DATA_W +: DATA_W] = regs_nxt[rd_a];
      else
        bus.rd_data[p*DATA_W +: DATA_W] = regs[rd_a];
    end
  end

  // NOTE: the register array is reset because reads and the mirror must show zero during reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      dirty_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= regs_nxt[r];
      dirty_q <= dirty_set | (dirty_q & ~dirty_clr_v);
      ovf_q   <= ovf_set | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.dirty = dirty_q;
  assign bus.ovf   = ovf_q;

  for (genvar i = 0; i < PER_CNT; i++) begin : g_mirror
    assign bus.per_regs[i*DATA_W +: DATA_W] = regs[PER_BASE+i];
  end
endmodule
